// File: rtl/spram_arb_pkg.sv
// Shared types for the two-port SPRAM arbiter: FSM states, port count and request bundle.
package spram_arb_pkg;

    localparam int unsigned N_PORTS = 2;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        wen;
        logic        ren;
    } req_t;

endpackage

// File: rtl/spram_arb_pick.sv
// Two-way winner select. SPRAM_ARB_ROUND_ROBIN_EN selects round-robin on a tie;
// otherwise port 0 has fixed priority.
module spram_arb_pick
    import spram_arb_pkg::*;
(
    input  logic [N_PORTS-1:0] i_req,
    input  logic               i_last,
    output logic               o_winner
);

`ifdef SPRAM_ARB_ROUND_ROBIN_EN
    always_comb begin
        if (&i_req) begin
            o_winner = ~i_last;
        end else begin
            o_winner = i_req[1] & ~i_req[0];
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = i_last;
    assign o_winner      = i_req[1] & ~i_req[0];
`endif

endmodule

// File: rtl/spram_arbiter.sv
// Serialises two requesters onto one SPRAM port with completion timeout.
// Tie-break policy is set by SPRAM_ARB_ROUND_ROBIN_EN (see spram_arb_pick).
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    input  logic [3:0]  r0_wmask,
    input  logic        r0_wen,
    input  logic        r0_ren,
    output logic [31:0] r0_rdata,
    output logic        r0_done,
    output logic        r0_err,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    input  logic [3:0]  r1_wmask,
    input  logic        r1_wen,
    input  logic        r1_ren,
    output logic [31:0] r1_rdata,
    output logic        r1_done,
    output logic        r1_err,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wmask,
    output logic        m_wen,
    output logic        m_ren,
    input  logic [31:0] m_rdata,
    input  logic        m_done,
    input  logic        m_active,
    output logic        grant
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    req_t [N_PORTS-1:0] w_req;
    logic [N_PORTS-1:0] w_req_vec;
    logic               w_winner;
    req_t               w_sel;

    state_e             r_state, w_state_next;
    req_t               r_m, w_m_next;
    logic               r_grant, w_grant_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [31:0]        r_resp, w_resp_next;
    logic               r_err, w_err_next;
    logic               r_rd, w_rd_next;
    logic               w_done0, w_done1;

    assign w_req[0] = '{addr: r0_addr, wdata: r0_wdata, wmask: r0_wmask,
                        wen: r0_wen, ren: r0_ren};
    assign w_req[1] = '{addr: r1_addr, wdata: r1_wdata, wmask: r1_wmask,
                        wen: r1_wen, ren: r1_ren};
    assign w_req_vec = {r1_wen | r1_ren, r0_wen | r0_ren};
    assign w_sel     = w_req[w_winner];

    spram_arb_pick u_pick (
        .i_req    (w_req_vec),
        .i_last   (r_grant),
        .o_winner (w_winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_m     <= '0;
            r_grant <= 1'b1;
            r_cnt   <= '0;
            r_resp  <= '0;
            r_err   <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_m     <= w_m_next;
            r_grant <= w_grant_next;
            r_cnt   <= w_cnt_next;
            r_resp  <= w_resp_next;
            r_err   <= w_err_next;
            r_rd    <= w_rd_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_m_next     = r_m;
        w_grant_next = r_grant;
        w_cnt_next   = r_cnt;
        w_resp_next  = r_resp;
        w_err_next   = r_err;
        w_rd_next    = r_rd;
        case (r_state)
            StIdle: begin
                if (|w_req_vec) begin
                    w_m_next     = w_sel;
                    // A write with ren also set is issued as a pure write.
                    w_m_next.ren = w_sel.ren & ~w_sel.wen;
                    w_rd_next    = ~w_sel.wen;
                    w_grant_next = w_winner;
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                w_m_next.wen = 1'b0;
                w_m_next.ren = 1'b0;
                if (!m_active) begin
                    w_err_next   = 1'b1;
                    w_resp_next  = '0;
                    w_state_next = StResp;
                end else begin
                    w_cnt_next   = '0;
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (m_done) begin
                    w_resp_next  = r_rd ? m_rdata : '0;
                    w_err_next   = 1'b0;
                    w_state_next = StResp;
                end else if (r_cnt == CNT_LAST) begin
                    w_resp_next  = '0;
                    w_err_next   = 1'b1;
                    w_state_next = StResp;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Responses decode from registers only, so reset clears them immediately.
    always_comb begin
        w_done0  = (r_state == StResp) && (r_grant == 1'b0);
        w_done1  = (r_state == StResp) && (r_grant == 1'b1);
        r0_done  = w_done0;
        r0_err   = w_done0 & r_err;
        r0_rdata = w_done0 ? r_resp : '0;
        r1_done  = w_done1;
        r1_err   = w_done1 & r_err;
        r1_rdata = w_done1 ? r_resp : '0;
    end

    assign m_addr  = r_m.addr;
    assign m_wdata = r_m.wdata;
    assign m_wmask = r_m.wmask;
    assign m_wen   = r_m.wen;
    assign m_ren   = r_m.ren;
    assign grant   = r_grant;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed self-checking bench for spram_arbiter (default fixed-priority build).
module tb_spram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic [3:0]  r0_wmask;
    logic        r0_wen, r0_ren, r0_done, r0_err;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic [3:0]  r1_wmask;
    logic        r1_wen, r1_ren, r1_done, r1_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wmask;
    logic        m_wen, m_ren, m_done, m_active, grant;

    int n_vec = 0;
    int n_err = 0;

    spram_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wmask(r0_wmask),
        .r0_wen(r0_wen), .r0_ren(r0_ren), .r0_rdata(r0_rdata),
        .r0_done(r0_done), .r0_err(r0_err),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wmask(r1_wmask),
        .r1_wen(r1_wen), .r1_ren(r1_ren), .r1_rdata(r1_rdata),
        .r1_done(r1_done), .r1_err(r1_err),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
        .m_wen(m_wen), .m_ren(m_ren), .m_rdata(m_rdata),
        .m_done(m_done), .m_active(m_active), .grant(grant)
    );

    always #5 clk = ~clk;

    // Advance n cycles; outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        r0_addr = '0; r0_wdata = '0; r0_wmask = '0; r0_wen = 0; r0_ren = 0;
        r1_addr = '0; r1_wdata = '0; r1_wmask = '0; r1_wen = 0; r1_ren = 0;
        m_rdata = '0; m_done = 0; m_active = 1;
        @(negedge clk);
        n_vec++; if (grant !== 1'b1) begin n_err++; $display("FAIL reset_grant got=%b exp=1", grant); end
        n_vec++; if ({m_addr, m_wdata, m_wmask, m_wen, m_ren} !== 70'd0) begin
            n_err++; $display("FAIL reset_m got addr=%h wen=%b ren=%b exp all 0", m_addr, m_wen, m_ren); end
        n_vec++; if ({r0_done, r0_err, r0_rdata, r1_done, r1_err, r1_rdata} !== 68'd0) begin
            n_err++; $display("FAIL reset_resp got d0=%b d1=%b exp 0", r0_done, r1_done); end
        rst = 1'b0;
        tick(1);
    endtask

    // Tie from reset: port 0 served first, then port 1's write (wen+ren issued as write).
    task automatic test_simultaneous();
        r0_addr = 32'hF000_0020; r0_ren = 1; m_rdata = 32'h1234_5678;
        r1_addr = 32'hF000_0040; r1_wdata = 32'hCAFE_F00D; r1_wmask = 4'b0011;
        r1_wen = 1; r1_ren = 1;
        tick(1);
        n_vec++; if (m_addr !== 32'hF000_0020 || grant !== 1'b0) begin
            n_err++; $display("FAIL sim_first got addr=%h grant=%b exp F0000020/0", m_addr, grant); end
        tick(1); m_done = 1;
        tick(1); m_done = 0;
        n_vec++; if (r0_done !== 1'b1 || r0_rdata !== 32'h1234_5678 || r1_done !== 1'b0) begin
            n_err++; $display("FAIL sim_r0_done got d0=%b data=%h d1=%b exp 1/12345678/0", r0_done, r0_rdata, r1_done); end
        r0_ren = 0;
        tick(2);
        n_vec++; if (m_addr !== 32'hF000_0040 || m_wdata !== 32'hCAFE_F00D || m_wmask !== 4'b0011) begin
            n_err++; $display("FAIL sim_r1_issue got addr=%h wdata=%h mask=%b", m_addr, m_wdata, m_wmask); end
        n_vec++; if (m_wen !== 1'b1 || m_ren !== 1'b0 || grant !== 1'b1) begin
            n_err++; $display("FAIL sim_r1_strobe got wen=%b ren=%b grant=%b exp 1/0/1", m_wen, m_ren, grant); end
        tick(1); m_done = 1;
        tick(1); m_done = 0;
        n_vec++; if (r1_done !== 1'b1 || r1_err !== 1'b0 || r1_rdata !== 32'd0 || r0_done !== 1'b0) begin
            n_err++; $display("FAIL sim_r1_done got d1=%b err=%b data=%h d0=%b exp 1/0/0/0", r1_done, r1_err, r1_rdata, r0_done); end
        r1_wen = 0; r1_ren = 0;
        tick(1);
    endtask

    task automatic test_single_read();
        r0_addr = 32'hF000_0010; r0_ren = 1; m_rdata = 32'hDEAD_BEEF;
        tick(1);
        n_vec++; if (m_addr !== 32'hF000_0010 || m_ren !== 1'b1 || m_wen !== 1'b0) begin
            n_err++; $display("FAIL rd_issue got addr=%h ren=%b wen=%b", m_addr, m_ren, m_wen); end
        tick(1);
        n_vec++; if (m_ren !== 1'b0 || m_addr !== 32'hF000_0010 || r0_done !== 1'b0) begin
            n_err++; $display("FAIL rd_wait got ren=%b addr=%h done=%b exp 0/F0000010/0", m_ren, m_addr, r0_done); end
        m_done = 1;
        tick(1); m_done = 0;
        n_vec++; if (r0_done !== 1'b1 || r0_err !== 1'b0 || r0_rdata !== 32'hDEAD_BEEF || r1_done !== 1'b0) begin
            n_err++; $display("FAIL rd_done got d=%b e=%b data=%h d1=%b exp 1/0/DEADBEEF/0", r0_done, r0_err, r0_rdata, r1_done); end
        r0_ren = 0;
        tick(1);
        n_vec++; if (r0_done !== 1'b0 || r0_rdata !== 32'd0) begin
            n_err++; $display("FAIL rd_pulse got d=%b data=%h exp 0/0", r0_done, r0_rdata); end
    endtask

    task automatic test_fixed_priority();
        int c0 = 0;
        int c1 = 0;
        r0_addr = 32'hF000_0050; r0_ren = 1;
        r1_addr = 32'hF000_0060; r1_ren = 1;
        m_done = 1;
        for (int i = 0; i < 11; i++) begin
            tick(1);
            c0 += int'(r0_done);
            c1 += int'(r1_done);
        end
        n_vec++; if (c0 !== 3 || c1 !== 0 || r0_done !== 1'b1) begin
            n_err++; $display("FAIL fixed_starve got r0=%0d r1=%0d exp 3/0", c0, c1); end
        r0_ren = 0;
        c1 = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            c1 += int'(r1_done);
        end
        tick(1);
        n_vec++; if (c1 !== 0 || r1_done !== 1'b1 || grant !== 1'b1) begin
            n_err++; $display("FAIL fixed_r1_done got early=%0d d1=%b exp 0/1", c1, r1_done); end
        r1_ren = 0; m_done = 0;
        tick(1);
    endtask

    task automatic test_undecoded();
        r1_addr = 32'h0000_1000; r1_ren = 1; m_active = 0; m_rdata = 32'hA5A5_A5A5;
        tick(1);
        n_vec++; if (r1_done !== 1'b0) begin n_err++; $display("FAIL undec_early got d1=%b exp 0", r1_done); end
        tick(1);
        n_vec++; if (r1_done !== 1'b1 || r1_err !== 1'b1 || r1_rdata !== 32'd0 || r0_done !== 1'b0) begin
            n_err++; $display("FAIL undec_done got d=%b e=%b data=%h exp 1/1/0", r1_done, r1_err, r1_rdata); end
        r1_ren = 0; m_active = 1;
        tick(1);
    endtask

    // stale=1 pulses m_done during ISSUE only; it must be ignored.
    task automatic test_timeout(input bit stale);
        int early = 0;
        r0_addr = 32'hF000_0070; r0_ren = 1; m_done = 0;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            early += int'(r0_done);
            m_done = stale && (i == 1);
        end
        n_vec++; if (early !== 0) begin n_err++; $display("FAIL timeout_early stale=%0d got %0d exp 0", stale, early); end
        tick(1);
        n_vec++; if (r0_done !== 1'b1 || r0_err !== 1'b1 || r0_rdata !== 32'd0) begin
            n_err++; $display("FAIL timeout_done stale=%0d got d=%b e=%b data=%h exp 1/1/0", stale, r0_done, r0_err, r0_rdata); end
        r0_ren = 0;
        tick(1);
    endtask

    task automatic test_reset_in_wait();
        int seen = 0;
        r0_addr = 32'hF000_0080; r0_ren = 1; m_done = 0; m_rdata = 32'h0BAD_C0DE;
        tick(2);
        rst = 1'b1;
        #1;
        n_vec++; if (m_addr !== 32'd0 || m_ren !== 1'b0 || grant !== 1'b1 || r0_done !== 1'b0) begin
            n_err++; $display("FAIL rst_async got addr=%h ren=%b grant=%b exp 0/0/1", m_addr, m_ren, grant); end
        for (int i = 0; i < 2; i++) begin
            tick(1);
            seen += int'(r0_done);
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rst_nodone got %0d exp 0", seen); end
        rst = 1'b0;
        tick(1);
        n_vec++; if (m_addr !== 32'hF000_0080 || m_ren !== 1'b1) begin
            n_err++; $display("FAIL rst_reissue got addr=%h ren=%b", m_addr, m_ren); end
        tick(1); m_done = 1;
        tick(1); m_done = 0;
        n_vec++; if (r0_done !== 1'b1 || r0_err !== 1'b0 || r0_rdata !== 32'h0BAD_C0DE) begin
            n_err++; $display("FAIL rst_after got d=%b e=%b data=%h exp 1/0/0BADC0DE", r0_done, r0_err, r0_rdata); end
        r0_ren = 0;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single_read();
        test_fixed_priority();
        test_undecoded();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Two-port arbiter that shares the single-port SPRAM memory segment between two requesters (instruction fetch on port 0, load/store or DMA on port 1). It sits between the requesters and the SPRAM memory module and speaks the same addr/wdata/wmask/wen/ren/rdata/done bus on both sides. It serialises transactions, holds the memory address stable for the memory's completion detect, and routes read data and completion back to the winning requester.

## Interface
- TIMEOUT_CYCLES, 8: cycles to wait for `m_done` in WAIT before failing the transaction.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rN_addr  in  32  requester N address (N = 0, 1); byte address, word-aligned.
- rN_wdata  in  32  requester N write data.
- rN_wmask  in  4  requester N byte write mask.
- rN_wen / rN_ren  in  1  requester N write / read request; level, held until `rN_done`.
- rN_rdata  out  32  read data to requester N; valid only while `rN_done` is high.
- rN_done  out  1  one-cycle completion pulse to requester N.
- rN_err  out  1  qualifies `rN_done`: 1 = address not decoded or timeout.
- m_addr, m_wdata, m_wmask  out  32/32/4  registered memory-side request.
- m_wen, m_ren  out  1  memory-side strobes, registered.
- m_rdata  in  32  memory read data.
- m_done, m_active  in  1  memory completion and address-decode hit.
- grant  out  1  index of current or last owner, for debug.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - A port is requesting when `wen|ren` is high. If `wen` and `ren` are both high, the port is treated as a write.
  - If any port requests, pick the winner, register its addr/wdata/wmask/wen/ren onto `m_*`, set `grant`, and go to ISSUE.
- ISSUE: `m_*` held.
  - If `m_active`=0: go to RESP with err=1.
  - Otherwise go to WAIT, clear the timeout counter, and drop `m_wen`/`m_ren` to 0. `m_addr` stays held.
- WAIT:
  - `m_done`=1: capture `m_rdata` into a response register and go to RESP with err=0.
  - Counter reaches TIMEOUT_CYCLES−1 without `m_done`: go to RESP with err=1.
  - `m_done` is never sampled in ISSUE, so a stale done from an earlier transaction to the same address is ignored.
- RESP:
  - Pulse `rG_done` for one cycle, where G is the owner. `rG_rdata` carries the response register; `rG_err` carries the error flag.
  - Go to IDLE.
  - On a write or an error, `rG_rdata` = 0.
- Requester rule: drop `wen`/`ren` in the cycle after `done`. A request still high in IDLE is a new transaction.
- Non-owner outputs: `rN_done`=0, `rN_err`=0, `rN_rdata`=0.
- Requests from the losing port are not latched. They are re-evaluated at the next IDLE.

## Timing
- Reset values:
  - state=IDLE, `grant`=1 (so port 0 wins the first tie).
  - All `m_*` = 0; all `rN_done`/`rN_err`/`rN_rdata` = 0; timeout counter = 0.
- Latency: request seen in IDLE at cycle T → ISSUE T+1 → WAIT T+2 → `done` pulse at T+3, given `m_done` at T+2.
- Throughput: one transaction per 4 cycles.
- Timeout path: `done` with err at T+2+TIMEOUT_CYCLES.
- Reset asserted mid-transaction: everything returns to reset values immediately, with no `done` pulse. A write already strobed into SPRAM is not rolled back.

## Configuration
- `SPRAM_ARB_ROUND_ROBIN_EN` defined:
  - On a simultaneous request, the port ≠ `grant` wins.
  - A single requester always wins.
- Undefined: fixed priority, port 0 always wins; `grant` is still updated for debug.

## Structure
- Shared package `spram_arb_pkg`: state enum (IDLE, ISSUE, WAIT, RESP), N_PORTS=2, and a packed struct {addr, wdata, wmask, wen, ren} for request muxing.
- One sub-module, `spram_arb_pick`: the 2-way winner select, taking the request vector and last grant and returning the winner. It is combinational and is the only code that depends on the macro.

## Test plan
- Single read: r0 reads 0xF0000010 with memory returning 0xDEADBEEF and `m_done` at WAIT → `r0_done`=1, `r0_err`=0, `r0_rdata`=0xDEADBEEF at T+3; `r1_done` stays 0.
- Simultaneous requests, round-robin build: r0 read and r1 write (wmask=4'b0011) in the same cycle from reset → r0 served first (T+3); r1's write appears on `m_*` at T+5; r1 `done` at T+7.
- Fixed-priority build: both ports request continuously → r0 wins every IDLE and r1 never gets `done`; drop r0 → r1 `done` 4 cycles later.
- Undecoded address: r1 reads 0x00001000 with `m_active`=0 → `r1_done`=1, `r1_err`=1, `r1_rdata`=0 at T+2.
- Timeout: with TIMEOUT_CYCLES=8, `m_done` held 0 → `done` with err=1 at T+10. Stale done: `m_done` forced high during ISSUE only → ignored and the transaction times out.
- Reset in WAIT: assert `rst` at T+2 → all outputs 0 asynchronously, no `done` pulse; the first request after reset completes normally at T'+3.
